cnn_win_sched: RTL

- Sequences 3x3 convolution-window reads from the 1-bit input image RAM into cnn_core.
- Tracks how many pixels the write side has stored. Launches a window only when its bottom-right pixel has been written and the core is idle.
- Issues nine tap addresses per window in raster order and flags first/last tap.
- Walks anchors across the image with row wrap-around and signals frame completion.

---
 rtl/cnn_win_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cnn_win_sched.sv
// 3x3 window read scheduler for the 1-bit image RAM feeding cnn_core.
// Optional idle stall counter enabled by defining CNN_WIN_SCHED_STALL_CNT_EN.
module cnn_win_sched #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] wr_cnt,
  input  logic              core_bsy,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              tap_vld,
  output logic              tap_first,
  output logic              tap_last,
  output logic [ADDR_W-1:0] win_idx,
  output logic              frame_done
`ifdef CNN_WIN_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] AnchorInit = ADDR_W'(2 * IMG_W + 2);
  localparam logic [ADDR_W-1:0] ColInit    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ColLast    = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LastWin    = ADDR_W'((IMG_W - 2) * (IMG_H - 2) - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StAdv, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] anchor_q, anchor_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] win_q, win_d;
  logic [3:0]        tap_q, tap_d;
  logic              tap_vld_q, tap_first_q, tap_last_q, frame_done_q;
  logic              tap_vld_d, tap_first_d, tap_last_d, frame_done_d;
  logic              fetch;
  logic              ready;
  logic              launch;
  logic [ADDR_W-1:0] tap_off;

  assign ready  = anchor_q < wr_cnt;
  assign launch = ready && !core_bsy;
  assign fetch  = (state_q == StFetch);

  // Distance from the bottom-right anchor back to tap k (raster order).
  always_comb begin
    tap_off = '0;
    unique case (tap_q)
      4'd0:    tap_off = ADDR_W'(2 * IMG_W + 2);
      4'd1:    tap_off = ADDR_W'(2 * IMG_W + 1);
      4'd2:    tap_off = ADDR_W'(2 * IMG_W);
      4'd3:    tap_off = ADDR_W'(IMG_W + 2);
      4'd4:    tap_off = ADDR_W'(IMG_W + 1);
      4'd5:    tap_off = ADDR_W'(IMG_W);
      4'd6:    tap_off = ADDR_W'(2);
      4'd7:    tap_off = ADDR_W'(1);
      4'd8:    tap_off = '0;
      default: tap_off = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    anchor_d     = anchor_q;
    col_d        = col_q;
    win_d        = win_q;
    tap_d        = tap_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StFetch;
          tap_d   = 4'd0;
        end
      end
      StFetch: begin
        if (tap_q == 4'd8) begin
          state_d = StAdv;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      StAdv: begin
        // Skipping two columns at row end lands the anchor on column 2 of the next row.
        if (col_q == ColLast) begin
          anchor_d = anchor_q + ADDR_W'(3);
          col_d    = ColInit;
        end else begin
          anchor_d = anchor_q + ADDR_W'(1);
          col_d    = col_q + ADDR_W'(1);
        end
        if (win_q == LastWin) begin
          state_d      = StDone;
          frame_done_d = 1'b1;
        end else begin
          win_d   = win_q + ADDR_W'(1);
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      state_d      = StIdle;
      anchor_d     = AnchorInit;
      col_d        = ColInit;
      win_d        = '0;
      tap_d        = 4'd0;
      frame_done_d = 1'b0;
    end
  end

  // clr also kills the registered tap strobe so an aborted tap never surfaces.
  assign tap_vld_d   = fetch && !clr;
  assign tap_first_d = fetch && !clr && (tap_q == 4'd0);
  assign tap_last_d  = fetch && !clr && (tap_q == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      anchor_q     <= AnchorInit;
      col_q        <= ColInit;
      win_q        <= '0;
      tap_q        <= 4'd0;
      tap_vld_q    <= 1'b0;
      tap_first_q  <= 1'b0;
      tap_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      anchor_q     <= anchor_d;
      col_q        <= col_d;
      win_q        <= win_d;
      tap_q        <= tap_d;
      tap_vld_q    <= tap_vld_d;
      tap_first_q  <= tap_first_d;
      tap_last_q   <= tap_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = fetch;
  assign rd_addr    = fetch ? (anchor_q - tap_off) : '0;
  assign tap_vld    = tap_vld_q;
  assign tap_first  = tap_first_q;
  assign tap_last   = tap_last_q;
  assign win_idx    = win_q;
  assign frame_done = frame_done_q;

`ifdef CNN_WIN_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (clr) begin
      stall_d = '0;
    end else if ((state_q == StIdle) && !launch && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
